mem_access_ctrl: RTL and testbench

Memory-stage load/store controller sitting directly upstream of `data_mem`. Accepts one load/store request at a time from the execute stage and decodes RISC-V funct3 into `data_mem` store/load type codes. Flags misaligned, out-of-range and illegal accesses without touching memory, sequences the synchronous read, and returns a single writeback beat per request. Also keeps saturating load/store/error counters for debug.

---
 rtl/mem_pkg.sv | 49 ++++
 rtl/mem_access_ctrl_if.sv | 30 +++
 rtl/mem_access_decode.sv | 55 +++++
 rtl/mem_access_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types for the memory-stage load/store controller and its decoder.
package mem_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned F3_W  = 3;

  typedef enum logic [1:0] {
    ST_SB = 2'b00,
    ST_SH = 2'b01,
    ST_SW = 2'b10
  } store_type_e;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b011,
    LD_LHU = 3'b100
  } load_type_e;

  localparam logic [F3_W-1:0] F3_BYTE  = 3'b000;
  localparam logic [F3_W-1:0] F3_HALF  = 3'b001;
  localparam logic [F3_W-1:0] F3_WORD  = 3'b010;
  localparam logic [F3_W-1:0] F3_BYTEU = 3'b100;
  localparam logic [F3_W-1:0] F3_HALFU = 3'b101;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_RANGE    = 2'b10,
    CAUSE_ILLEGAL  = 2'b11
  } cause_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_RESP
  } state_e;

  typedef struct packed {
    logic        err;
    cause_e      cause;
    store_type_e store_type;
    load_type_e  load_type;
  } decode_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/writeback bus between the execute stage and the memory-stage controller.
interface mem_access_ctrl_if;
  import mem_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [F3_W-1:0]       req_funct3;
  logic [XLEN-1:0]       req_addr;
  logic [XLEN-1:0]       req_wdata;
  logic [REG_W-1:0]      req_rd;

  logic                  wb_valid;
  logic                  wb_is_load;
  logic [REG_W-1:0]      wb_rd;
  logic [XLEN-1:0]       wb_data;
  logic                  wb_err;
  cause_e                wb_cause;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    input  req_ready, wb_valid, wb_is_load, wb_rd, wb_data, wb_err, wb_cause
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    output req_ready, wb_valid, wb_is_load, wb_rd, wb_data, wb_err, wb_cause
  );

endinterface

// File: rtl/mem_access_decode.sv
// Combinational funct3/address decode into data_mem type codes plus error classification.
module mem_access_decode
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic                   we,
  input  logic [F3_W-1:0]        funct3,
  input  logic [XLEN-ADDR_W-1:0] addr_hi,
  input  logic [1:0]             addr_lo,
  output decode_t                dec_c
);

  logic illegal;
  logic is_half;
  logic is_word;
  logic out_of_range;
  logic misaligned;

  always_comb begin
    illegal          = 1'b0;
    is_half          = 1'b0;
    is_word          = 1'b0;
    dec_c.store_type = ST_SB;
    dec_c.load_type  = LD_LB;
    if (we) begin
      case (funct3)
        F3_BYTE: dec_c.store_type = ST_SB;
        F3_HALF: begin dec_c.store_type = ST_SH; is_half = 1'b1; end
        F3_WORD: begin dec_c.store_type = ST_SW; is_word = 1'b1; end
        default: illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_BYTE:  dec_c.load_type = LD_LB;
        F3_HALF:  begin dec_c.load_type = LD_LH;  is_half = 1'b1; end
        F3_WORD:  begin dec_c.load_type = LD_LW;  is_word = 1'b1; end
        F3_BYTEU: dec_c.load_type = LD_LBU;
        F3_HALFU: begin dec_c.load_type = LD_LHU; is_half = 1'b1; end
        default:  illegal = 1'b1;
      endcase
    end

    out_of_range = |addr_hi;
    misaligned   = (is_half && addr_lo[0]) || (is_word && (addr_lo != 2'b00));

    // Error priority: illegal funct3 over range over alignment.
    if (illegal)           dec_c.cause = CAUSE_ILLEGAL;
    else if (out_of_range) dec_c.cause = CAUSE_RANGE;
    else if (misaligned)   dec_c.cause = CAUSE_MISALIGN;
    else                   dec_c.cause = CAUSE_NONE;
    dec_c.err = illegal || out_of_range || misaligned;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller: one request at a time, sequences data_mem, returns one writeback beat.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  mem_access_ctrl_if.slave    bus,
  input  logic                flush,
  output logic                dmem_write,
  output logic [1:0]          dmem_store_type,
  output logic [2:0]          dmem_load_type,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [XLEN-1:0]     dmem_wdata,
  input  logic [XLEN-1:0]     dmem_rdata,
  output logic [CNT_W-1:0]    load_cnt,
  output logic [CNT_W-1:0]    store_cnt,
  output logic [CNT_W-1:0]    err_cnt
);

  decode_t dec;

  mem_access_decode #(.ADDR_W(ADDR_W)) u_decode (
    .we      (bus.req_we),
    .funct3  (bus.req_funct3),
    .addr_hi (bus.req_addr[XLEN-1:ADDR_W]),
    .addr_lo (bus.req_addr[1:0]),
    .dec_c   (dec)
  );

  state_e              state_q, state_d;
  logic                killed_q, killed_d;
  logic                wb_valid_q, wb_valid_d;
  logic                dmem_write_d;
  logic [1:0]          store_type_d;
  logic [2:0]          load_type_d;
  logic [ADDR_W-1:0]   dmem_addr_d;
  logic [XLEN-1:0]     wdata_d;
  logic                wb_is_load_d;
  logic [REG_W-1:0]    wb_rd_d;
  logic [XLEN-1:0]     wb_data_d;
  logic                wb_err_d;
  cause_e              wb_cause_d;
  logic                load_inc, store_inc, err_inc;

  // A flush landing in the response cycle of a load still has to hide the beat.
  assign bus.wb_valid = wb_valid_q && !(flush && bus.wb_is_load);

  always_comb begin
    state_d      = state_q;
    killed_d     = killed_q;
    wb_valid_d   = 1'b0;
    dmem_write_d = 1'b0;
    store_type_d = dmem_store_type;
    load_type_d  = dmem_load_type;
    dmem_addr_d  = dmem_addr;
    wdata_d      = dmem_wdata;
    wb_is_load_d = bus.wb_is_load;
    wb_rd_d      = bus.wb_rd;
    wb_data_d    = bus.wb_data;
    wb_err_d     = bus.wb_err;
    wb_cause_d   = bus.wb_cause;
    load_inc     = 1'b0;
    store_inc    = 1'b0;
    err_inc      = 1'b0;

    case (state_q)
      S_IDLE: begin
        killed_d = 1'b0;
        if (bus.req_valid) begin
          wb_is_load_d = !bus.req_we;
          wb_rd_d      = bus.req_rd;
          wb_data_d    = '0;
          wb_err_d     = dec.err;
          wb_cause_d   = dec.cause;
          if (dec.err) begin
            state_d    = S_RESP;
            wb_valid_d = 1'b1;
            err_inc    = 1'b1;
          end else begin
            state_d     = S_ISSUE;
            dmem_addr_d = bus.req_addr[ADDR_W-1:0];
            if (bus.req_we) begin
              dmem_write_d = 1'b1;
              store_type_d = dec.store_type;
              wdata_d      = bus.req_wdata;
              store_inc    = 1'b1;
            end else begin
              load_type_d = dec.load_type;
              load_inc    = 1'b1;
            end
          end
        end
      end
      S_ISSUE: begin
        if (bus.wb_is_load) begin
          state_d  = S_CAPTURE;
          killed_d = killed_q || flush;
        end else begin
          state_d    = S_RESP;
          wb_valid_d = 1'b1;
        end
      end
      S_CAPTURE: begin
        state_d    = S_RESP;
        wb_data_d  = dmem_rdata;
        wb_valid_d = !(killed_q || flush);
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      killed_q        <= 1'b0;
      wb_valid_q      <= 1'b0;
      bus.req_ready   <= 1'b1;
      dmem_write      <= 1'b0;
      dmem_store_type <= '0;
      dmem_load_type  <= '0;
      dmem_addr       <= '0;
      dmem_wdata      <= '0;
      bus.wb_is_load  <= 1'b0;
      bus.wb_rd       <= '0;
      bus.wb_data     <= '0;
      bus.wb_err      <= 1'b0;
      bus.wb_cause    <= CAUSE_NONE;
    end else begin
      state_q         <= state_d;
      killed_q        <= killed_d;
      wb_valid_q      <= wb_valid_d;
      bus.req_ready   <= (state_d == S_IDLE);
      dmem_write      <= dmem_write_d;
      dmem_store_type <= store_type_d;
      dmem_load_type  <= load_type_d;
      dmem_addr       <= dmem_addr_d;
      dmem_wdata      <= wdata_d;
      bus.wb_is_load  <= wb_is_load_d;
      bus.wb_rd       <= wb_rd_d;
      bus.wb_data     <= wb_data_d;
      bus.wb_err      <= wb_err_d;
      bus.wb_cause    <= wb_cause_d;
    end
  end

  // Saturating debug counters, bumped at acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_cnt  <= '0;
      store_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (load_inc  && (load_cnt  != {CNT_W{1'b1}})) load_cnt  <= load_cnt  + CNT_W'(1);
      if (store_inc && (store_cnt != {CNT_W{1'b1}})) store_cnt <= store_cnt + CNT_W'(1);
      if (err_inc   && (err_cnt   != {CNT_W{1'b1}})) err_cnt   <= err_cnt   + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural byte-addressed data_mem model.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              dmem_write;
  logic [1:0]        dmem_store_type;
  logic [2:0]        dmem_load_type;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic [CNT_W-1:0]  load_cnt, store_cnt, err_cnt;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus.slave),
    .flush           (flush),
    .dmem_write      (dmem_write),
    .dmem_store_type (dmem_store_type),
    .dmem_load_type  (dmem_load_type),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_rdata      (dmem_rdata),
    .load_cnt        (load_cnt),
    .store_cnt       (store_cnt),
    .err_cnt         (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:(1<<ADDR_W)-1];
  int wr_cnt = 0;
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_read(input logic [ADDR_W-1:0] a, input logic [2:0] t);
    logic [ADDR_W-1:0] a1, a2, a3;
    logic [7:0]  b;
    logic [15:0] h;
    a1 = a + ADDR_W'(1);
    a2 = a + ADDR_W'(2);
    a3 = a + ADDR_W'(3);
    b = mem[a];
    h = {mem[a1], mem[a]};
    case (t)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return {mem[a3], mem[a2], mem[a1], mem[a]};
      3'b011:  return {24'h0, b};
      3'b100:  return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  // Synchronous-read, synchronous-write data_mem model.
  always @(posedge clk) begin
    if (dmem_write === 1'b1) begin
      wr_cnt++;
      mem[dmem_addr] = dmem_wdata[7:0];
      if (dmem_store_type != 2'b00) mem[dmem_addr + ADDR_W'(1)] = dmem_wdata[15:8];
      if (dmem_store_type == 2'b10) begin
        mem[dmem_addr + ADDR_W'(2)] = dmem_wdata[23:16];
        mem[dmem_addr + ADDR_W'(3)] = dmem_wdata[31:24];
      end
    end
    dmem_rdata <= mem_read(dmem_addr, dmem_load_type);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_rd     = rd;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
  endtask

  // Issue one request and check the response beat appears exactly lat edges after acceptance.
  task automatic xact(input string name, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                      input int lat, input logic [31:0] exp_data, input logic exp_err,
                      input logic [1:0] exp_cause);
    drive(we, f3, addr, wdata, rd);
    for (int i = 1; i < lat; i++) begin
      chk({name, ".wb_early"}, 32'(bus.wb_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    chk({name, ".wb_valid"},   32'(bus.wb_valid),   32'd1);
    chk({name, ".wb_is_load"}, 32'(bus.wb_is_load), 32'(!we));
    chk({name, ".wb_rd"},      32'(bus.wb_rd),      32'(rd));
    chk({name, ".wb_data"},    bus.wb_data,         exp_data);
    chk({name, ".wb_err"},     32'(bus.wb_err),     32'(exp_err));
    chk({name, ".wb_cause"},   32'(bus.wb_cause),   32'(exp_cause));
    @(posedge clk);
    #1;
    chk({name, ".wb_drop"},    32'(bus.wb_valid),   32'd0);
    chk({name, ".ready"},      32'(bus.req_ready),  32'd1);
  endtask

  initial begin
    int wr_before;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
    rst = 1'b0;
    flush = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    bus.req_rd = 5'd0;
    #12;
    chk("rst.ready",      32'(bus.req_ready),  32'd1);
    chk("rst.dmem_write", 32'(dmem_write),     32'd0);
    chk("rst.dmem_addr",  32'(dmem_addr),      32'd0);
    chk("rst.wb_valid",   32'(bus.wb_valid),   32'd0);
    chk("rst.wb_data",    bus.wb_data,         32'd0);
    chk("rst.load_cnt",   32'(load_cnt),       32'd0);
    @(negedge clk);
    rst = 1'b1;

    // SW then LW at 0
    wr_before = wr_cnt;
    xact("sw0", 1'b1, 3'b010, 32'h0, 32'h11223344, 5'd9, 2, 32'h0, 1'b0, 2'b00);
    chk("sw0.store_type", 32'(dmem_store_type), 32'd2);
    chk("sw0.wdata",      dmem_wdata,           32'h11223344);
    chk("sw0.writes",     32'(wr_cnt - wr_before), 32'd1);
    xact("lw0", 1'b0, 3'b010, 32'h0, 32'h0, 5'd7, 3, 32'h11223344, 1'b0, 2'b00);
    chk("lw0.load_type",  32'(dmem_load_type), 32'd2);

    // SB then sign/zero-extended byte loads
    xact("sb1", 1'b1, 3'b000, 32'h1, 32'h000000AA, 5'd0, 2, 32'h0, 1'b0, 2'b00);
    chk("sb1.store_type", 32'(dmem_store_type), 32'd0);
    xact("lb1", 1'b0, 3'b000, 32'h1, 32'h0, 5'd3, 3, 32'hFFFFFFAA, 1'b0, 2'b00);
    chk("lb1.load_type",  32'(dmem_load_type), 32'd0);
    xact("lbu1", 1'b0, 3'b100, 32'h1, 32'h0, 5'd4, 3, 32'h000000AA, 1'b0, 2'b00);
    chk("lbu1.load_type", 32'(dmem_load_type), 32'd3);

    // Error requests never touch memory
    wr_before = wr_cnt;
    xact("lh3",   1'b0, 3'b001, 32'h3,    32'h0,        5'd5, 1, 32'h0, 1'b1, 2'b01);
    xact("swoor", 1'b1, 3'b010, 32'h1000, 32'hDEADBEEF, 5'd6, 1, 32'h0, 1'b1, 2'b10);
    xact("ld111", 1'b0, 3'b111, 32'h0,    32'h0,        5'd8, 1, 32'h0, 1'b1, 2'b11);
    chk("err.writes",  32'(wr_cnt - wr_before), 32'd0);
    chk("err.err_cnt", 32'(err_cnt), 32'd3);

    // Flush during CAPTURE kills the beat
    drive(1'b0, 3'b010, 32'h0, 32'h0, 5'd10);
    chk("fl.issue_wb", 32'(bus.wb_valid), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    chk("fl.cap_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("fl.resp_wb",    32'(bus.wb_valid),  32'd0);
    chk("fl.resp_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("fl.idle_ready", 32'(bus.req_ready), 32'd1);
    chk("fl.idle_wb",    32'(bus.wb_valid),  32'd0);
    chk("cnt.load",  32'(load_cnt),  32'd4);
    chk("cnt.store", 32'(store_cnt), 32'd2);

    // Reset during ISSUE of a store aborts the write
    wr_before = wr_cnt;
    drive(1'b1, 3'b010, 32'h0, 32'hCAFEF00D, 5'd0);
    chk("ar.issue_write", 32'(dmem_write), 32'd1);
    rst = 1'b0;
    #1;
    chk("ar.dmem_write", 32'(dmem_write),  32'd0);
    chk("ar.dmem_wdata", dmem_wdata,       32'd0);
    chk("ar.dmem_addr",  32'(dmem_addr),   32'd0);
    chk("ar.ready",      32'(bus.req_ready), 32'd1);
    chk("ar.store_cnt",  32'(store_cnt),   32'd0);
    @(posedge clk);
    #1;
    chk("ar.wb_valid",   32'(bus.wb_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    chk("ar.writes", 32'(wr_cnt - wr_before), 32'd0);
    xact("lwar", 1'b0, 3'b010, 32'h0, 32'h0, 5'd11, 3, 32'h1122AA44, 1'b0, 2'b00);

    // Load counter saturation
    for (int i = 0; i < 10; i++)
      xact("lwsat", 1'b0, 3'b010, 32'h0, 32'h0, 5'd12, 3, 32'h1122AA44, 1'b0, 2'b00);
    chk("sat.load_mid", 32'(load_cnt), 32'd11);
    for (int i = 0; i < 10; i++)
      xact("lwsat", 1'b0, 3'b010, 32'h0, 32'h0, 5'd12, 3, 32'h1122AA44, 1'b0, 2'b00);
    chk("sat.load_cnt", 32'(load_cnt), 32'hF);
    chk("sat.err_cnt",  32'(err_cnt),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
